// File: rtl/parking_lot_pkg.sv
//------------------------------------------------------------------------------
// Module  : parking_lot_pkg
// Purpose : Shared types, widths and small helpers for the parking-lot
//           request scheduler (job kinds, FSM states, floor-mask helpers).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package parking_lot_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int PLATE_W    = 16;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    JOB_NONE = 2'd0,
    JOB_IN   = 2'd1,
    JOB_OUT  = 2'd2,
    JOB_LEAK = 2'd3
  } job_kind_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } sched_state_e;

  // Isolate the least-significant set bit (lowest flooded floor wins).
  function automatic logic [NUM_FLOORS-1:0] lowest_bit(input logic [NUM_FLOORS-1:0] v);
    return v & (~v + NUM_FLOORS'(1));
  endfunction

  // Convert a one-hot floor mask (bit f-1) into floor number f.
  function automatic logic [FLOOR_W-1:0] onehot_to_floor(input logic [NUM_FLOORS-1:0] oh);
    logic [FLOOR_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (oh[i]) f = FLOOR_W'(i + 1);
    end
    return f;
  endfunction

  // Number of floors with a pending evacuation job.
  function automatic logic [3:0] popcount(input logic [NUM_FLOORS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/parking_req_fifo.sv
//------------------------------------------------------------------------------
// Module  : parking_req_fifo
// Purpose : Synchronous plate FIFO with full/empty/count flags. A push while
//           full is dropped unless a pop happens on the same edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module parking_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap as DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/parking_request_scheduler.sv
//------------------------------------------------------------------------------
// Module  : parking_request_scheduler
// Purpose : Buffers park/retrieve/leak requests and presents one job at a
//           time to the elevator FSM (priority leak > out > in).
// Config  : PARKING_SCHED_AGING_EN - forces a waiting park job through after
//           MAX_OUT_BURST consecutive retrieve jobs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module parking_request_scheduler
  import parking_lot_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_OUT_BURST = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PLATE_W-1:0]    license_plate,
  input  logic                  in_mode,
  input  logic                  out_mode,
  input  logic                  leakage,
  input  logic [FLOOR_W-1:0]    leakage_floor,
  input  logic                  todo_done,
  output logic                  todo_exists,
  output logic                  todo_in,
  output logic                  todo_out,
  output logic                  todo_leak_move,
  output logic [PLATE_W-1:0]    todo_license_plate,
  output logic [FLOOR_W-1:0]    todo_floor,
  output logic [NUM_FLOORS-1:0] blocked_floors,
  output logic [3:0]            pending_cnt,
  output logic                  overflow,
  output logic                  req_error
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two of at least 2");
  end
  if (MAX_OUT_BURST < 1) begin : g_bad_out_burst
    $error("MAX_OUT_BURST must be at least 1");
  end

  sched_state_e          r_state;
  logic                  r_todo_exists, r_todo_in, r_todo_out, r_todo_leak;
  logic [PLATE_W-1:0]    r_todo_plate;
  logic [FLOOR_W-1:0]    r_todo_floor;
  logic [NUM_FLOORS-1:0] r_blocked, r_leak_pending;
  logic                  r_overflow, r_req_error;

  logic                  w_plate_zero, w_illegal, w_in_req, w_out_req;
  logic                  w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [CW-1:0]         w_in_count, w_out_count;
  logic [PLATE_W-1:0]    w_in_head, w_out_head;
  logic                  w_in_pop, w_out_pop, w_force_in;
  logic [NUM_FLOORS-1:0] w_leak_oh, w_leak_set, w_leak_clr;
  job_kind_e             w_sel_kind;

  assign w_plate_zero = (license_plate == '0);
  assign w_illegal    = (in_mode & out_mode) | ((in_mode | out_mode) & w_plate_zero);
  assign w_in_req     = in_mode & ~out_mode & ~w_plate_zero;
  assign w_out_req    = out_mode & ~in_mode & ~w_plate_zero;

  parking_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PLATE_W)) u_in_fifo (
    .i_clk(clock), .i_rst_n(reset), .i_push(w_in_req), .i_data(license_plate),
    .i_pop(w_in_pop), .o_data(w_in_head), .o_full(w_in_full),
    .o_empty(w_in_empty), .o_count(w_in_count)
  );

  parking_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PLATE_W)) u_out_fifo (
    .i_clk(clock), .i_rst_n(reset), .i_push(w_out_req), .i_data(license_plate),
    .i_pop(w_out_pop), .o_data(w_out_head), .o_full(w_out_full),
    .o_empty(w_out_empty), .o_count(w_out_count)
  );

`ifdef PARKING_SCHED_AGING_EN
  localparam int BURST_W = $clog2(MAX_OUT_BURST + 1);
  logic [BURST_W-1:0] r_out_burst;

  // Count consecutive retrieve selections; a park selection restarts the run.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_burst <= '0;
    end else if (w_sel_kind == JOB_IN) begin
      r_out_burst <= '0;
    end else if (w_sel_kind == JOB_OUT && r_out_burst != BURST_W'(MAX_OUT_BURST)) begin
      r_out_burst <= r_out_burst + BURST_W'(1);
    end
  end

  assign w_force_in = (r_out_burst == BURST_W'(MAX_OUT_BURST)) & ~w_in_empty;
`else
  assign w_force_in = 1'b0;
`endif

  // Leak mask for this edge: only floors 1..7 that are not already flooded.
  always_comb begin
    w_leak_oh = '0;
    if (leakage && leakage_floor != '0) w_leak_oh = NUM_FLOORS'(1) << (leakage_floor - FLOOR_W'(1));
    w_leak_set = w_leak_oh & ~r_blocked;
  end

  // Job selection in IDLE: lowest leak floor, then out head, then in head.
  always_comb begin
    w_sel_kind = JOB_NONE;
    w_leak_clr = '0;
    w_in_pop   = 1'b0;
    w_out_pop  = 1'b0;
    if (r_state == S_IDLE) begin
      if (|r_leak_pending) begin
        w_sel_kind = JOB_LEAK;
        w_leak_clr = lowest_bit(r_leak_pending);
      end else if (w_force_in || (w_out_empty && !w_in_empty)) begin
        w_sel_kind = JOB_IN;
        w_in_pop   = 1'b1;
      end else if (!w_out_empty) begin
        w_sel_kind = JOB_OUT;
        w_out_pop  = 1'b1;
      end
    end
  end

  // Sticky flood/overflow flags, pending leak set and the one-cycle error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_blocked      <= '0;
      r_leak_pending <= '0;
      r_overflow     <= 1'b0;
      r_req_error    <= 1'b0;
    end else begin
      r_blocked      <= r_blocked | w_leak_set;
      r_leak_pending <= (r_leak_pending & ~w_leak_clr) | w_leak_set;
      r_overflow     <= r_overflow | (w_in_req & w_in_full & ~w_in_pop)
                                   | (w_out_req & w_out_full & ~w_out_pop);
      r_req_error    <= w_illegal;
    end
  end

  // Two-state job FSM with registered todo_* outputs held for the whole job.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_todo_exists <= 1'b0;
      r_todo_in     <= 1'b0;
      r_todo_out    <= 1'b0;
      r_todo_leak   <= 1'b0;
      r_todo_plate  <= '0;
      r_todo_floor  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sel_kind != JOB_NONE) begin
            r_state       <= S_BUSY;
            r_todo_exists <= 1'b1;
            r_todo_in     <= (w_sel_kind == JOB_IN);
            r_todo_out    <= (w_sel_kind == JOB_OUT);
            r_todo_leak   <= (w_sel_kind == JOB_LEAK);
            r_todo_plate  <= (w_sel_kind == JOB_IN)  ? w_in_head  :
                             (w_sel_kind == JOB_OUT) ? w_out_head : '0;
            r_todo_floor  <= onehot_to_floor(w_leak_clr);
          end
        end
        S_BUSY: begin
          if (todo_done) begin
            r_state       <= S_IDLE;
            r_todo_exists <= 1'b0;
            r_todo_in     <= 1'b0;
            r_todo_out    <= 1'b0;
            r_todo_leak   <= 1'b0;
            r_todo_plate  <= '0;
            r_todo_floor  <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign todo_exists        = r_todo_exists;
  assign todo_in            = r_todo_in;
  assign todo_out           = r_todo_out;
  assign todo_leak_move     = r_todo_leak;
  assign todo_license_plate = r_todo_plate;
  assign todo_floor         = r_todo_floor;
  assign blocked_floors     = r_blocked;
  assign overflow           = r_overflow;
  assign req_error          = r_req_error;
  assign pending_cnt        = 4'(w_in_count) + 4'(w_out_count) + popcount(r_leak_pending);

endmodule

`default_nettype wire
